// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared types and constants for the ysyx_22050550 instruction fetch unit.
// Holds the FSM encoding, the NOP filler word and the fetch word-select helper.
package ysyx_22050550_ifu_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;

  typedef logic [63:0] ysyx_22050550_RegBus;

  typedef enum logic [1:0] {
    ysyx_22050550_IFU_IDLE = 2'd0,
    ysyx_22050550_IFU_ADDR = 2'd1,
    ysyx_22050550_IFU_DATA = 2'd2,
    ysyx_22050550_IFU_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [INST_W-1:0] ysyx_22050550_NOP       = 32'h0000_0013;
  localparam logic [1:0]        ysyx_22050550_RESP_OKAY = 2'b00;

  // A 64-bit beat holds two instructions; PC bit 2 picks the upper one.
  function automatic logic [INST_W-1:0] select_word(input logic hi,
                                                    input logic [DATA_W-1:0] beat);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050550_ifu_if.sv
// Bundle of the PC-register, memory read channel and decode-side signals of the IFU.
// The master modport is the fetch unit; slave is everything around it.
interface ysyx_22050550_ifu_if;
  import ysyx_22050550_ifu_pkg::*;

  logic [ADDR_W-1:0] npc;
  logic              flush;
  logic              ready;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic              If_valid;
  logic [ADDR_W-1:0] If_pc;
  logic [INST_W-1:0] If_inst;
  logic              If_err;
  logic              Id_ready;

  modport master (
    input  npc, flush, arready, rvalid, rdata, rresp, Id_ready,
    output ready, arvalid, araddr, rready, If_valid, If_pc, If_inst, If_err
  );

  modport slave (
    output npc, flush, arready, rvalid, rdata, rresp, Id_ready,
    input  ready, arvalid, araddr, rready, If_valid, If_pc, If_inst, If_err
  );

endinterface

// File: rtl/ysyx_22050550.sv
// Shared single-bit register helper; the fetch unit itself lives in rtl/ysyx_22050550_ifu.sv.
// Two-state helper: registers a single bit, kept for shared tooling of this slice.
module ysyx_22050550_bit_reg (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= 1'b0;
    else        q <= d;
  end
endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Multi-cycle instruction fetch: one aligned 64-bit read per instruction, word select,
// valid/ready hand-off to decode, and redirect (flush) abandonment of in-flight fetches.
module ysyx_22050550_ifu
  import ysyx_22050550_ifu_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  ysyx_22050550_ifu_if.master  bus
);

  ifu_state_e        state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              err_q, err_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ysyx_22050550_IFU_IDLE;
      drop_q   <= 1'b0;
      req_pc_q <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    req_pc_d = req_pc_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    err_d    = err_q;

    unique case (state_q)
      ysyx_22050550_IFU_IDLE: begin
        drop_d   = 1'b0;
        req_pc_d = bus.npc;
        // A misaligned PC never reaches memory; decode sees a faulting NOP instead.
        if (bus.npc[1:0] != 2'b00) begin
          inst_d  = ysyx_22050550_NOP;
          err_d   = 1'b1;
          pc_d    = bus.npc;
          state_d = ysyx_22050550_IFU_OUT;
        end else begin
          state_d = ysyx_22050550_IFU_ADDR;
        end
      end

      ysyx_22050550_IFU_ADDR: begin
        if (bus.flush)   drop_d  = 1'b1;
        if (bus.arready) state_d = ysyx_22050550_IFU_DATA;
      end

      ysyx_22050550_IFU_DATA: begin
        if (bus.flush) drop_d = 1'b1;
        if (bus.rvalid) begin
          // Stale responses are still drained so the memory side stays in step.
          if (drop_q || bus.flush) begin
            drop_d  = 1'b0;
            state_d = ysyx_22050550_IFU_IDLE;
          end else begin
            inst_d  = select_word(req_pc_q[2], bus.rdata);
            err_d   = (bus.rresp != ysyx_22050550_RESP_OKAY);
            pc_d    = req_pc_q;
            state_d = ysyx_22050550_IFU_OUT;
          end
        end
      end

      ysyx_22050550_IFU_OUT: begin
        if (bus.flush || bus.Id_ready) state_d = ysyx_22050550_IFU_IDLE;
      end

      default: state_d = ysyx_22050550_IFU_IDLE;
    endcase
  end

  assign bus.arvalid  = (state_q == ysyx_22050550_IFU_ADDR);
  assign bus.rready   = (state_q == ysyx_22050550_IFU_DATA);
  assign bus.If_valid = (state_q == ysyx_22050550_IFU_OUT);
  assign bus.araddr   = {req_pc_q[ADDR_W-1:3], 3'b000};
  assign bus.If_pc    = pc_q;
  assign bus.If_inst  = inst_q;
  assign bus.If_err   = err_q;
  // Flush beats Id_ready: the PC register advances on its own when redirected.
  assign bus.ready    = (state_q == ysyx_22050550_IFU_OUT) & bus.Id_ready & ~bus.flush;

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Directed bench for ysyx_22050550_ifu: drives memory and decode by hand and checks
// addresses, fetched words, error flags, handshake pulses and cycle counts.
module tb_ysyx_22050550_ifu;
  import ysyx_22050550_ifu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  ysyx_22050550_ifu_if bus ();

  ysyx_22050550_ifu dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in an IDLE cycle; runs the memory side until If_valid, counting edges.
  task automatic fetch(input logic [63:0] pc, input logic [63:0] data, input logic [1:0] resp,
                       input int aw, input int rw, output int lat, output bit saw_ar);
    int aw_n = 0;
    int rw_n = 0;
    bit done = 1'b0;
    bus.npc = pc; bus.rdata = data; bus.rresp = resp;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.Id_ready = 1'b0; bus.flush = 1'b0;
    lat = 0; saw_ar = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clock); #2;
      lat++;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      if (bus.arvalid) begin
        saw_ar = 1'b1;
        check("araddr", bus.araddr, {pc[63:3], 3'b000});
        if (aw_n == aw) bus.arready = 1'b1; else aw_n++;
      end
      if (bus.rready) begin
        if (rw_n == rw) bus.rvalid = 1'b1; else rw_n++;
      end
      if (bus.If_valid) done = 1'b1;
    end
    check("fetch_done", {63'd0, done}, 64'd1);
  endtask

  task automatic expect_out(input logic [63:0] pc, input logic [31:0] inst, input logic err);
    check("If_pc", bus.If_pc, pc);
    check("If_inst", {32'd0, bus.If_inst}, {32'd0, inst});
    check("If_err", {63'd0, bus.If_err}, {63'd0, err});
  endtask

  // Decode takes the instruction; returns having landed in the next IDLE cycle.
  task automatic accept();
    bus.Id_ready = 1'b1;
    #1;
    check("ready_pulse", {63'd0, bus.ready}, 64'd1);
    @(posedge clock); #2;
    bus.Id_ready = 1'b0;
    check("ready_low_after", {63'd0, bus.ready}, 64'd0);
    check("valid_low_after", {63'd0, bus.If_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    bit saw_ar;

    bus.npc = 64'h8000_0000; bus.flush = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b0;
    bus.rdata = '0; bus.rresp = 2'b00; bus.Id_ready = 1'b1;

    #12;
    check("rst_arvalid", {63'd0, bus.arvalid}, 64'd0);
    check("rst_rready", {63'd0, bus.rready}, 64'd0);
    check("rst_araddr", bus.araddr, 64'd0);
    check("rst_If_valid", {63'd0, bus.If_valid}, 64'd0);
    check("rst_If_pc", bus.If_pc, 64'd0);
    check("rst_If_inst", {32'd0, bus.If_inst}, 64'd0);
    check("rst_If_err", {63'd0, bus.If_err}, 64'd0);
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    #10 reset = 1'b1;   // mid-cycle release; the next cycle is IDLE

    // Zero-wait fetch of the low word; OUT after 3 edges, back in IDLE after 4.
    fetch(64'h8000_0000, 64'h0010_0073_0000_0413, 2'b00, 0, 0, lat, saw_ar);
    check("t1_lat", lat, 3);
    check("t1_saw_ar", {63'd0, saw_ar}, 64'd1);
    expect_out(64'h8000_0000, 32'h0000_0413, 1'b0);
    accept();

    // Upper word of the same beat.
    fetch(64'h8000_0004, 64'h0010_0073_0000_0413, 2'b00, 0, 0, lat, saw_ar);
    check("t2_lat", lat, 3);
    expect_out(64'h8000_0004, 32'h0010_0073, 1'b0);
    accept();

    // arready on the 3rd ADDR cycle, rvalid on the 2nd DATA cycle: OUT on 7th cycle counting IDLE.
    fetch(64'h8000_0008, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 2, 1, lat, saw_ar);
    check("t3_lat", lat, 6);
    expect_out(64'h8000_0008, 32'hCCCC_DDDD, 1'b0);
    accept();

    // Flush in DATA; response arrives 2 cycles later and is discarded.
    bus.npc = 64'h8000_0100; bus.arready = 1'b1; bus.rvalid = 1'b0; bus.Id_ready = 1'b1;
    bus.rdata = 64'h1234_5678_9ABC_DEF0;
    @(posedge clock); #2;
    check("f_arvalid", {63'd0, bus.arvalid}, 64'd1);
    check("f_araddr", bus.araddr, 64'h8000_0100);
    @(posedge clock); #2;
    bus.arready = 1'b0;
    check("f_rready0", {63'd0, bus.rready}, 64'd1);
    bus.flush = 1'b1; bus.npc = 64'h8000_0200;
    #1 check("f_ready0", {63'd0, bus.ready}, 64'd0);
    @(posedge clock); #2;
    bus.flush = 1'b0;
    check("f_rready1", {63'd0, bus.rready}, 64'd1);
    @(posedge clock); #2;
    bus.rvalid = 1'b1;
    check("f_rready2", {63'd0, bus.rready}, 64'd1);
    @(posedge clock); #2;
    bus.rvalid = 1'b0;
    check("f_valid", {63'd0, bus.If_valid}, 64'd0);
    check("f_ready1", {63'd0, bus.ready}, 64'd0);
    check("f_idle", {62'd0, bus.arvalid, bus.rready}, 64'd0);
    fetch(64'h8000_0200, 64'hDEAD_BEEF_00A0_0513, 2'b00, 0, 0, lat, saw_ar);
    check("f_next_lat", lat, 3);
    expect_out(64'h8000_0200, 32'h00A0_0513, 1'b0);
    accept();

    // Flush and Id_ready together in OUT: no ready, valid drops.
    fetch(64'h8000_020C, 64'h0000_0093_1111_1111, 2'b00, 0, 0, lat, saw_ar);
    expect_out(64'h8000_020C, 32'h0000_0093, 1'b0);
    bus.flush = 1'b1; bus.Id_ready = 1'b1;
    #1 check("fo_ready", {63'd0, bus.ready}, 64'd0);
    @(posedge clock); #2;
    bus.flush = 1'b0; bus.Id_ready = 1'b0;
    check("fo_valid", {63'd0, bus.If_valid}, 64'd0);

    // Misaligned PC: straight to OUT with a faulting NOP, no read issued.
    fetch(64'h8000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, 0, lat, saw_ar);
    check("ma_lat", lat, 1);
    check("ma_saw_ar", {63'd0, saw_ar}, 64'd0);
    expect_out(64'h8000_0002, 32'h0000_0013, 1'b1);
    accept();

    // Error response.
    fetch(64'h8000_0018, 64'h1111_1111_2222_2222, 2'b10, 0, 0, lat, saw_ar);
    expect_out(64'h8000_0018, 32'h2222_2222, 1'b1);
    accept();

    // Asynchronous reset while in ADDR.
    bus.npc = 64'h8000_0010; bus.arready = 1'b0;
    @(posedge clock); #2;
    check("ra_arvalid_pre", {63'd0, bus.arvalid}, 64'd1);
    reset = 1'b0;
    #1;
    check("ra_arvalid", {63'd0, bus.arvalid}, 64'd0);
    check("ra_araddr", bus.araddr, 64'd0);
    check("ra_If_inst", {32'd0, bus.If_inst}, 64'd0);
    @(posedge clock); #2;
    check("ra_hold", {62'd0, bus.arvalid, bus.rready}, 64'd0);
    reset = 1'b1;
    fetch(64'h8000_0010, 64'h0000_0513_0000_0000, 2'b00, 0, 0, lat, saw_ar);
    check("ra_lat", lat, 3);
    expect_out(64'h8000_0010, 32'h0000_0000, 1'b0);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_ifu.md
# ysyx_22050550_ifu

Multi-cycle instruction fetch unit between the PC register and the IF/ID boundary. Samples the PC register's `npc` and issues one AXI-style read per instruction. Selects the 32-bit instruction from the 64-bit beat and presents it to decode under a valid/ready handshake. Its `ready` output is the PC register's advance enable; the fetch is abandoned when decode redirects the PC.

## Interface
- `ADDR_W`, 64: PC/address width.
- `DATA_W`, 64: memory read beat width.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `npc`  in  ADDR_W  next PC from the PC register.
- `flush`  in  1  redirect taken in decode (jump type != 0 and decode valid).
- `ready`  out  1  one-cycle pulse: instruction accepted by decode, so the PC register advances.
- `arvalid` / `arready`  out / in  1 / 1  read-address handshake.
- `araddr`  out  ADDR_W  fetch address, 8-byte aligned (`req_pc` with bits [2:0] cleared).
- `rvalid` / `rready`  in / out  1 / 1  read-data handshake.
- `rdata`  in  DATA_W  read beat.
- `rresp`  in  2  0 = OKAY; any other value is an error.
- `If_valid`  out  1  instruction available to decode.
- `If_pc`  out  ADDR_W  PC of the presented instruction.
- `If_inst`  out  32  instruction word.
- `If_err`  out  1  access fault (bad `rresp` or misaligned PC).
- `Id_ready`  in  1  decode accepts the instruction.

## Operation
- FSM states: IDLE, ADDR, DATA, OUT.
- IDLE: latch `npc` into `req_pc`.
  - If `npc[1:0]` != 0: load `If_inst` = 0x00000013, set `If_err` = 1, go to OUT.
  - Otherwise go to ADDR.
- ADDR: `arvalid` = 1 and `araddr` is held stable. On `arready` go to DATA.
- DATA: `rready` = 1. On `rvalid`:
  - Capture `If_inst` = `req_pc[2]` ? `rdata[63:32]` : `rdata[31:0]`.
  - Set `If_err` = (`rresp` != 0) and `If_pc` = `req_pc`.
  - Go to OUT.
- OUT: `If_valid` = 1. When `Id_ready` = 1 and `flush` = 0: `ready` = 1, then go to IDLE.
- `drop` flag:
  - Set by `flush` in ADDR or DATA. `arvalid` is never withdrawn once raised.
  - A response arriving with `drop` set (or with `flush` in the same cycle) is consumed and discarded; go to IDLE and produce no output.
  - Cleared on entry to IDLE.
- `flush` in OUT: deassert `If_valid` next cycle, go to IDLE, no `ready` pulse. The PC register self-advances on redirect. Flush wins over a simultaneous `Id_ready`.
- `flush` in IDLE: no effect; `npc` already carries the redirect target.
- `If_valid`, `If_pc`, `If_inst` and `If_err` are stable while in OUT.

## Timing
- Reset values: state IDLE; `drop` = 0; `req_pc` = 0.
- Outputs during reset: `arvalid` = 0, `rready` = 0, `araddr` = 0, `If_valid` = 0, `If_pc` = 0, `If_inst` = 0, `If_err` = 0, `ready` = 0.
- Reset mid-transaction: returns to IDLE immediately and asynchronously. The memory side is reset by the same signal.
- `arvalid`, `rready` and `If_valid` decode from the registered state only; there is no combinational path from inputs.
- `ready` = (state == OUT) & `Id_ready` & ~`flush`. This is combinational, and it is the only input-to-output path.
- Best-case throughput: 4 cycles per instruction (IDLE, ADDR, DATA, OUT), each state lasting 1 cycle when the memory and decode respond immediately.
- `npc` is sampled in IDLE, which is the cycle after the `ready` edge, so it already reflects the advanced PC.
- Each extra wait cycle on `arready`, `rvalid` or `Id_ready` adds exactly 1 cycle.

## Structure
- Shared define file contents:
  - state encodings `ysyx_22050550_IFU_IDLE/ADDR/DATA/OUT` (2 bits);
  - `ysyx_22050550_NOP` = 32'h00000013;
  - `ysyx_22050550_RESP_OKAY` = 2'b00;
  - the existing `ysyx_22050550_RegBus`.
- No sub-module. The FSM, the `req_pc`/output registers and the word-select mux live in this single module, in an estimated ~200 lines.

## Test plan
- Reset release, `npc` = 0x80000000, zero-wait memory returning `rdata` = 0x00100073_00000413, `Id_ready` = 1 → `araddr` = 0x80000000; `If_inst` = 0x00000413, `If_pc` = 0x80000000; `ready` pulses once; next fetch starts 4 cycles after the first.
- `npc` = 0x80000004, same `rdata` → `araddr` = 0x80000000, `If_inst` = 0x00100073.
- `arready` delayed by 3 cycles, `rvalid` by 2 → `araddr` is stable throughout; `If_valid` rises 7 cycles after IDLE.
- `flush` asserted in DATA with `rvalid` 2 cycles later → response consumed with `rready` = 1; `If_valid` stays 0; no `ready` pulse; next `araddr` is taken from the redirected `npc`.
- `flush` and `Id_ready` both 1 in OUT → `ready` = 0; `If_valid` = 0 next cycle.
- `npc` = 0x80000002 → no `arvalid` issued; `If_valid` = 1, `If_err` = 1, `If_inst` = 0x00000013.
- `rresp` = 2 → `If_err` = 1.
- `reset` pulled low while in ADDR → `arvalid` drops immediately and state is IDLE.
